// File: rtl/foo_unwrap_pkg.sv
// Constants and stage payload for the foo_unwrap decoder (inverse of foo: x = y - 3).
// FOO_UNWRAP_WRAP_FLAG_EN adds a wrap flag bit to the payload.
package foo_unwrap_pkg;

    localparam int FOO_UNWRAP_DATA_WIDTH = 32;
    localparam int FOO_UNWRAP_S0_DEC     = 1;
    localparam int FOO_UNWRAP_S1_DEC     = 1;
    localparam int FOO_UNWRAP_LATENCY    = 3;

    typedef struct packed {
        logic [FOO_UNWRAP_DATA_WIDTH-1:0] dat;
`ifdef FOO_UNWRAP_WRAP_FLAG_EN
        logic                             flag;
`endif
    } foo_unwrap_payload_t;

endpackage

// File: rtl/foo_unwrap_stage_reg.sv
// Valid/ready pipeline register: 1 cycle; loads when empty or downstream enabled, else holds.
// en_out feeds the upstream stage so bubbles collapse under a downstream stall.
module foo_unwrap_stage_reg
    import foo_unwrap_pkg::*;
#(
    parameter type payload_t = foo_unwrap_payload_t
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en_in,
    input  logic     valid,
    input  payload_t data,
    output logic     en_out,
    output logic     q_valid,
    output payload_t q_data
);

    assign en_out = !q_valid || en_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (en_out) begin
            q_valid <= valid;
            q_data  <= data;
        end
    end

endmodule

// File: rtl/foo_unwrap.sv
// Decodes foo's stream (out = y - 3 mod 2^W) through 3 registered stages, 3-cycle latency.
// Full-throughput valid/ready backpressure; optional wrap_err under FOO_UNWRAP_WRAP_FLAG_EN.
module foo_unwrap
    import foo_unwrap_pkg::*;
#(
    parameter int DATA_WIDTH = FOO_UNWRAP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] y,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  output_valid,
    input  logic                  output_ready
`ifdef FOO_UNWRAP_WRAP_FLAG_EN
    ,
    output logic                  wrap_err
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
`ifdef FOO_UNWRAP_WRAP_FLAG_EN
        logic                  flag;
`endif
    } stage_t;

    stage_t p0_d, p0_q, p1_d, p1_q, p2_d, p2_q;
    logic   p0_valid, p1_valid, p2_valid;
    logic   en0, en1, en2;

    // Stage 0 undoes foo's second +1, which was applied to bits [W-1:1] only.
    always_comb begin
        p0_d     = '0;
        p0_d.dat = y;
`ifdef FOO_UNWRAP_WRAP_FLAG_EN
        p0_d.flag = (y < DATA_WIDTH'(3));
`endif
        p1_d     = p0_q;
        p1_d.dat = {p0_q.dat[DATA_WIDTH-1:1] - (DATA_WIDTH-1)'(FOO_UNWRAP_S0_DEC), p0_q.dat[0]};
        p2_d     = p1_q;
        p2_d.dat = p1_q.dat - DATA_WIDTH'(FOO_UNWRAP_S1_DEC);
    end

    foo_unwrap_stage_reg #(.payload_t(stage_t)) u_p0 (
        .clk     (clk),
        .rst     (rst),
        .en_in   (en1),
        .valid   (input_valid),
        .data    (p0_d),
        .en_out  (en0),
        .q_valid (p0_valid),
        .q_data  (p0_q)
    );

    foo_unwrap_stage_reg #(.payload_t(stage_t)) u_p1 (
        .clk     (clk),
        .rst     (rst),
        .en_in   (en2),
        .valid   (p0_valid),
        .data    (p1_d),
        .en_out  (en1),
        .q_valid (p1_valid),
        .q_data  (p1_q)
    );

    foo_unwrap_stage_reg #(.payload_t(stage_t)) u_p2 (
        .clk     (clk),
        .rst     (rst),
        .en_in   (output_ready),
        .valid   (p1_valid),
        .data    (p2_d),
        .en_out  (en2),
        .q_valid (p2_valid),
        .q_data  (p2_q)
    );

    assign input_ready  = en0;
    assign out          = p2_q.dat;
    assign output_valid = p2_valid;
`ifdef FOO_UNWRAP_WRAP_FLAG_EN
    assign wrap_err     = p2_q.flag;
`endif

endmodule
